keypad_time_entry_ctrl: RTL and testbench
=========================================

// Module: keypad_time_entry_ctrl
// PURPOSE
//  Front end of the microwave time-entry path. Samples the raw 10-key keypad and
//  debounces each press with a settle counter. Validates single-key presses and
//  shifts each accepted digit into a 4-digit BCD MM:SS register. The register
//  feeds the cook-timer load path. The block owns the settle counter: it clears
//  it, enables it and reads its terminal flag.
// PARAMETERS
//  SETTLE_CYCLES  4   consecutive stable cycles before a press or release counts (>=2)
//  CNT_W          3   settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  clock        in   1   system clock; all state changes on the rising edge
//  clear        in   1   asynchronous, active-high reset
//  keypad       in   10  raw key lines, one-hot: bit n = digit n; all zero = idle
//  entry_en     in   1   1 = accept digits (oven stopped); 0 = presses tracked, not stored
//  clear_entry  in   1   synchronous; zero the digits and drop time_loaded
//  sec_ones     out  4   BCD seconds units
//  sec_tens     out  4   BCD seconds tens
//  min_ones     out  4   BCD minutes units
//  min_tens     out  4   BCD minutes tens
//  time_loaded  out  1   1 = at least one digit accepted since the last clear/clear_entry
//  key_valid    out  1   one-cycle pulse when a digit is shifted in
//  key_error    out  1   one-cycle pulse when a settled press is rejected
// BEHAVIOUR
//  Reset (clear=1, async): FSM=IDLE, all digits 0, time_loaded/key_valid/key_error 0,
//   settle count 0, sampled code 0.
//  FSM states: IDLE, SETTLE, LATCH, RELEASE.
//  IDLE    keypad==0: stay. keypad!=0: sample keypad into code_q, clear count, go to SETTLE.
//  SETTLE  keypad==code_q: count++.
//          keypad==0: go to IDLE.
//          keypad changed to another nonzero value: re-sample it, clear count, stay.
//          count==SETTLE_CYCLES-1 with keypad==code_q: go to LATCH.
//  LATCH   One cycle.
//          code_q one-hot and entry_en=1: shift left
//           (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit);
//           pulse key_valid; set time_loaded.
//          code_q not one-hot: pulse key_error; no shift.
//          entry_en=0: no shift and no pulses.
//          Next state RELEASE; clear count.
//  RELEASE keypad==0: count++. keypad!=0: clear count.
//          count==SETTLE_CYCLES-1 with keypad==0: go to IDLE.
//          A key held indefinitely therefore yields exactly one digit (no auto-repeat).
//  Latency: digit visible SETTLE_CYCLES+1 edges after a stable press begins.
//  The settle count saturates; it never wraps during a hold.
//  clear_entry:
//   - Has priority over a LATCH shift in the same cycle.
//   - The digit is discarded; key_valid stays 0.
//   - The FSM still advances normally.
//  Mid-operation reset returns to IDLE. A key still held after reset is re-debounced.
//  key_valid and key_error are never both 1.
// CONFIGURATION
//  SECONDS_CLAMP_EN defined:
//   - In LATCH, reject the shift if sec_ones>5, since it would make sec_tens>5.
//   - On rejection: pulse key_error; digits unchanged.
//  SECONDS_CLAMP_EN undefined:
//   - Any digit is accepted. Values like 0:75 are legal and are normalised downstream.
// STRUCTURE
//  Shared package microondas_pkg:
//   - FSM state encoding.
//   - BCD digit typedef (4 bits).
//   - Keypad width constant KEYS=10.
//   - One-hot-to-BCD encode function.
//  Sub-module settle_counter #(CNT_W, SETTLE_CYCLES):
//   - Ports: clock, clear, restart (sync), inc.
//   - Output: done at count==SETTLE_CYCLES-1, saturating.
//   - Instantiated once; shared by SETTLE and RELEASE.
// TESTING (SETTLE_CYCLES=4)
//  - Hold key 5 for 6 cycles, then release 4 cycles -> one key_valid;
//    digits 00:05; time_loaded=1.
//  - Press 1,2,3,4 in sequence, each debounced -> 12:34, four key_valid pulses.
//    Fifth press 9 -> 23:49.
//  - Key 7 bounces (on 2, off 1, on 2, off) -> no key_valid; digits unchanged;
//    FSM back in IDLE.
//  - keypad=10'b0000010010 held 5 cycles -> key_error pulse, no shift.
//    Repeat with entry_en=0 on key 3 -> no pulses, no shift.
//  - clear_entry on the same edge as a LATCH of key 8 -> 00:00, time_loaded=0,
//    key_valid=0.
//  - Assert clear mid-SETTLE -> outputs 0 immediately; key held after release
//    is accepted after 4 cycles.
//    With SECONDS_CLAMP_EN, entering 1 then 7 then 2 -> third digit rejected with
//    key_error; digits stay 00:17.

Source files
------------

// File: rtl/microondas_pkg.sv
// Shared types and helpers for the microwave keypad / time-entry path.
package microondas_pkg;

  localparam int unsigned KEYS  = 10;
  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    LATCH   = 2'd2,
    RELEASE = 2'd3
  } key_state_e;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  // Index of the set bit of a one-hot key code (highest wins if several).
  function automatic bcd_t key_to_bcd(input logic [KEYS-1:0] code);
    bcd_t digit;
    digit = '0;
    for (int unsigned i = 0; i < KEYS; i++) begin
      if (code[i]) digit = bcd_t'(i);
    end
    return digit;
  endfunction

endpackage

// File: rtl/keypad_time_entry_ctrl_settle_counter.sv
// Saturating settle counter; done is high while the count sits at SETTLE_CYCLES-1.
module settle_counter #(
  parameter int unsigned CNT_W         = 3,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  input  logic inc,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Restart wins over increment; hold at LAST so a long press never wraps.
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (inc && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
      done    <= 1'b0;
    end else begin
      count_q <= count_d;
      done    <= (count_d == LAST);
    end
  end

endmodule

// File: rtl/keypad_time_entry_ctrl.sv
// Keypad debounce and MM:SS BCD digit entry for the cook timer.
// Optional SECONDS_CLAMP_EN rejects digits that would push seconds tens above 5.
module keypad_time_entry_ctrl
  import microondas_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [KEYS-1:0] keypad,
  input  logic            entry_en,
  input  logic            clear_entry,
  output logic [3:0]      sec_ones,
  output logic [3:0]      sec_tens,
  output logic [3:0]      min_ones,
  output logic [3:0]      min_tens,
  output logic            time_loaded,
  output logic            key_valid,
  output logic            key_error
);

  key_state_e      state_q;
  logic [KEYS-1:0] code_q;
  mmss_t           time_q;

  logic  cnt_restart;
  logic  cnt_inc;
  logic  cnt_done;
  logic  digit_ok;
  mmss_t time_shift;

  settle_counter #(
    .CNT_W         (CNT_W),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clock   (clock),
    .clear   (clear),
    .restart (cnt_restart),
    .inc     (cnt_inc),
    .done    (cnt_done)
  );

  // Counter runs only while the keypad matches the debounce target of the state.
  always_comb begin
    cnt_restart = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE:    cnt_restart = 1'b1;
      SETTLE:  if (keypad == code_q) cnt_inc = 1'b1; else cnt_restart = 1'b1;
      LATCH:   cnt_restart = 1'b1;
      RELEASE: if (keypad == '0) cnt_inc = 1'b1; else cnt_restart = 1'b1;
    endcase
  end

  // Candidate shifted register and accept decision for the settled code.
  always_comb begin
    time_shift.min_tens = time_q.min_ones;
    time_shift.min_ones = time_q.sec_tens;
    time_shift.sec_tens = time_q.sec_ones;
    time_shift.sec_ones = key_to_bcd(code_q);
`ifdef SECONDS_CLAMP_EN
    digit_ok = $onehot(code_q) && (time_q.sec_ones <= bcd_t'(5));
`else
    digit_ok = $onehot(code_q);
`endif
  end

  // The LATCH action is registered on the edge entering LATCH, so the pulse
  // and the new digits are visible during the LATCH cycle.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE;
      code_q      <= '0;
      time_q      <= '0;
      time_loaded <= 1'b0;
      key_valid   <= 1'b0;
      key_error   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_error <= 1'b0;
      case (state_q)
        IDLE: begin
          if (keypad != '0) begin
            code_q  <= keypad;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (keypad == '0) begin
            state_q <= IDLE;
          end else if (keypad != code_q) begin
            code_q <= keypad;
          end else if (cnt_done) begin
            state_q <= LATCH;
            if (entry_en) begin
              if (!digit_ok) begin
                key_error <= 1'b1;
              end else if (!clear_entry) begin
                time_q      <= time_shift;
                time_loaded <= 1'b1;
                key_valid   <= 1'b1;
              end
            end
          end
        end
        LATCH: state_q <= RELEASE;
        RELEASE: begin
          if ((keypad == '0) && cnt_done) state_q <= IDLE;
        end
      endcase
      if (clear_entry) begin
        time_q      <= '0;
        time_loaded <= 1'b0;
      end
    end
  end

  assign sec_ones = time_q.sec_ones;
  assign sec_tens = time_q.sec_tens;
  assign min_ones = time_q.min_ones;
  assign min_tens = time_q.min_tens;

endmodule

// File: tb/tb_keypad_time_entry_ctrl.sv
// Self-checking bench for keypad_time_entry_ctrl (SETTLE_CYCLES=4); honours SECONDS_CLAMP_EN.
module tb_keypad_time_entry_ctrl;
  import microondas_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic [9:0]  keypad;
  logic        entry_en;
  logic        clear_entry;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
  logic        time_loaded, key_valid, key_error;

  typedef struct packed {
    logic        err;
    logic [15:0] digits;
    logic        loaded;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] model_time;
  logic        model_loaded;
  int          n_checks;
  int          n_fail;

  keypad_time_entry_ctrl #(.SETTLE_CYCLES(4), .CNT_W(3)) dut (
    .clock       (clock),
    .clear       (clear),
    .keypad      (keypad),
    .entry_en    (entry_en),
    .clear_entry (clear_entry),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .min_tens    (min_tens),
    .time_loaded (time_loaded),
    .key_valid   (key_valid),
    .key_error   (key_error)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] digits_now();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // Advance one edge, then match any pulse against the scoreboard.
  task automatic tick();
    ev_t e;
    @(posedge clock);
    #1;
    if (key_valid && key_error) begin
      n_checks++;
      n_fail++;
      $display("FAIL both_pulses: key_valid=%0b key_error=%0b, required never both", key_valid, key_error);
    end
    if (key_valid || key_error) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b digits=%h, required no pulse", key_valid, key_error, digits_now());
      end else begin
        e = exp_q.pop_front();
        if ({key_error, digits_now(), time_loaded} !== {e.err, e.digits, e.loaded}) begin
          n_fail++;
          $display("FAIL pulse_event: err=%0b digits=%h loaded=%0b, required err=%0b digits=%h loaded=%0b",
                   key_error, digits_now(), time_loaded, e.err, e.digits, e.loaded);
        end
      end
    end
  endtask

  task automatic push_digit(input int d);
    ev_t e;
    model_time   = {model_time[11:0], 4'(d)};
    model_loaded = 1'b1;
    e.err    = 1'b0;
    e.digits = model_time;
    e.loaded = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_error();
    ev_t e;
    e.err    = 1'b1;
    e.digits = model_time;
    e.loaded = model_loaded;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [9:0] code, input int hold, input int rel);
    keypad = code;
    repeat (hold) tick();
    keypad = '0;
    repeat (rel) tick();
  endtask

  task automatic pulse_clear_entry();
    clear_entry = 1'b1;
    tick();
    clear_entry = 1'b0;
    model_time   = '0;
    model_loaded = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; keypad = '0; entry_en = 1'b1; clear_entry = 1'b0;
    model_time = '0; model_loaded = 1'b0;
    tick(); tick();
    n_checks++;
    if ({digits_now(), time_loaded, key_valid, key_error} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%0b/%0b/%0b, required all zero", digits_now(), time_loaded, key_valid, key_error);
    end
    clear = 1'b0;
    tick();
  endtask

  task automatic test_single_press();
    push_digit(5);
    keypad = 10'd1 << 5;
    repeat (4) tick();
    n_checks++;
    if (key_valid !== 1'b0 || digits_now() !== 16'h0000) begin
      n_fail++;
      $display("FAIL latency_early: valid=%0b digits=%h, required 0 and 0000", key_valid, digits_now());
    end
    tick();
    n_checks++;
    if (key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_edge5: valid=%0b, required 1", key_valid);
    end
    tick();
    keypad = '0;
    repeat (4) tick();
    n_checks++;
    if (digits_now() !== 16'h0005 || time_loaded !== 1'b1 || dut.state_q != IDLE) begin
      n_fail++;
      $display("FAIL single_press: digits=%h loaded=%0b state=%0d, required 0005 1 IDLE", digits_now(), time_loaded, dut.state_q);
    end
  endtask

  task automatic test_sequence();
    pulse_clear_entry();
    n_checks++;
    if (digits_now() !== 16'h0000 || time_loaded !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_entry_idle: digits=%h loaded=%0b, required 0000 0", digits_now(), time_loaded);
    end
    for (int d = 1; d <= 4; d++) begin
      push_digit(d);
      press(10'd1 << d, 5, 6);
    end
    n_checks++;
    if (digits_now() !== 16'h1234) begin
      n_fail++;
      $display("FAIL seq_1234: digits=%h, required 1234", digits_now());
    end
    push_digit(9);
    press(10'd1 << 9, 5, 6);
    n_checks++;
    if (digits_now() !== 16'h2349) begin
      n_fail++;
      $display("FAIL seq_shift_out: digits=%h, required 2349", digits_now());
    end
  endtask

  task automatic test_bounce();
    keypad = 10'd1 << 7; tick(); tick();
    keypad = '0;         tick();
    keypad = 10'd1 << 7; tick(); tick();
    keypad = '0;         tick(); tick();
    n_checks++;
    if (digits_now() !== model_time || dut.state_q != IDLE) begin
      n_fail++;
      $display("FAIL bounce: digits=%h state=%0d, required %h IDLE", digits_now(), dut.state_q, model_time);
    end
  endtask

  task automatic test_key_change();
    keypad = 10'd1 << 3; tick(); tick();
    push_digit(4);
    keypad = 10'd1 << 4;
    repeat (5) tick();
    keypad = '0;
    repeat (6) tick();
    n_checks++;
    if (digits_now() !== model_time) begin
      n_fail++;
      $display("FAIL key_change: digits=%h, required %h", digits_now(), model_time);
    end
  endtask

  task automatic test_errors();
    push_error();
    press(10'b0000010010, 5, 6);
    n_checks++;
    if (digits_now() !== model_time) begin
      n_fail++;
      $display("FAIL multi_key_no_shift: digits=%h, required %h", digits_now(), model_time);
    end
    entry_en = 1'b0;
    press(10'd1 << 3, 5, 6);
    entry_en = 1'b1;
    n_checks++;
    if (digits_now() !== model_time || time_loaded !== model_loaded) begin
      n_fail++;
      $display("FAIL entry_disabled: digits=%h loaded=%0b, required %h %0b", digits_now(), time_loaded, model_time, model_loaded);
    end
  endtask

  task automatic test_clear_collision();
    keypad = 10'd1 << 8;
    repeat (4) tick();
    clear_entry = 1'b1;
    tick();
    clear_entry = 1'b0;
    model_time = '0; model_loaded = 1'b0;
    n_checks++;
    if (digits_now() !== 16'h0000 || time_loaded !== 1'b0 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_vs_latch: digits=%h loaded=%0b valid=%0b, required 0000 0 0", digits_now(), time_loaded, key_valid);
    end
    keypad = '0;
    repeat (6) tick();
    n_checks++;
    if (dut.state_q != IDLE) begin
      n_fail++;
      $display("FAIL clear_vs_latch_fsm: state=%0d, required IDLE", dut.state_q);
    end
  endtask

  task automatic test_reset_mid();
    push_digit(2);
    press(10'd1 << 2, 5, 6);
    keypad = 10'd1 << 6;
    tick(); tick();
    clear = 1'b1;
    #1;
    n_checks++;
    if ({digits_now(), time_loaded, key_valid, key_error} !== 19'd0 || dut.state_q != IDLE) begin
      n_fail++;
      $display("FAIL async_clear: digits=%h loaded=%0b state=%0d, required zero IDLE", digits_now(), time_loaded, dut.state_q);
    end
    model_time = '0; model_loaded = 1'b0;
    tick();
    clear = 1'b0;
    push_digit(6);
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL redebounce_early: edge %0d valid=%0b, required 0", i, key_valid);
      end
    end
    tick();
    n_checks++;
    if (key_valid !== 1'b1 || digits_now() !== 16'h0006) begin
      n_fail++;
      $display("FAIL redebounce_accept: valid=%0b digits=%h, required 1 0006", key_valid, digits_now());
    end
    keypad = '0;
    repeat (6) tick();
  endtask

  task automatic test_seconds_clamp();
    pulse_clear_entry();
    push_digit(1);
    press(10'd1 << 1, 5, 6);
    push_digit(7);
    press(10'd1 << 7, 5, 6);
`ifdef SECONDS_CLAMP_EN
    push_error();
    press(10'd1 << 2, 5, 6);
    n_checks++;
    if (digits_now() !== 16'h0017) begin
      n_fail++;
      $display("FAIL clamp_reject: digits=%h, required 0017", digits_now());
    end
`else
    push_digit(2);
    press(10'd1 << 2, 5, 6);
    n_checks++;
    if (digits_now() !== 16'h0172) begin
      n_fail++;
      $display("FAIL no_clamp_accept: digits=%h, required 0172", digits_now());
    end
`endif
  endtask

  task automatic test_drained();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected pulses never seen, required 0", exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_press();
    test_sequence();
    test_bounce();
    test_key_change();
    test_errors();
    test_clear_collision();
    test_reset_mid();
    test_seconds_clamp();
    test_drained();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
